// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle core's instruction memory and its loader.
// Holds the memory geometry and the loader state encoding.
package riscv_pkg;

   localparam int IMEM_DEPTH  = 64;
   localparam int IMEM_ADDR_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } loader_state_t;

endpackage

// File: rtl/byte_to_word.sv
// Assembles four little-endian bytes into a 32-bit word and emits a registered
// one-cycle pulse when the fourth byte of a word has been taken.
module byte_to_word (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear_i,
   input  logic        byteValid_i,
   input  logic [7:0]  byteData_i,
   output logic        lastByte_o,
   output logic        wordValid_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        wordValid_q, wordValid_d;

   always_comb begin
      idx_d       = idx_q;
      word_d      = word_q;
      wordValid_d = 1'b0;
      if (clear_i) begin
         idx_d = 2'd0;
      end else if (byteValid_i) begin
         case (idx_q)
            2'd0: word_d[7:0]   = byteData_i;
            2'd1: word_d[15:8]  = byteData_i;
            2'd2: word_d[23:16] = byteData_i;
            2'd3: word_d[31:24] = byteData_i;
         endcase
         idx_d       = idx_q + 2'd1;
         wordValid_d = (idx_q == 2'd3);
      end
   end

   // A reset drops any partially assembled word without flagging it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         idx_q       <= 2'd0;
         word_q      <= 32'd0;
         wordValid_q <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         word_q      <= word_d;
         wordValid_q <= wordValid_d;
      end
   end

   assign lastByte_o  = (idx_q == 2'd3);
   assign wordValid_o = wordValid_q;
   assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory
// and holds the core in reset until a load has completed successfully.
module imem_loader
   import riscv_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [8:0]      DepthMax = 9'(DEPTH);
   localparam logic [ADDR_W:0] WordOne  = (ADDR_W + 1)'(1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        checksum_q, checksum_d;

   logic        xfer;
   logic        asmClear;
   logic        asmValid;
   logic        asmLast;
   logic        asmWordValid;
   logic [31:0] asmWord;

   assign xfer = in_valid & in_ready;

   // Address and word count advance on the edge that takes a word's last byte,
   // so they line up with the write pulse coming out of the assembler.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wordCnt_d  = wordCnt_q;
      addr_d     = addr_q;
      checksum_d = checksum_q;
      asmClear   = 1'b0;
      asmValid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (xfer) begin
               if ((in_data == 8'd0) || ({1'b0, in_data} > DepthMax)) begin
                  state_d = ST_ERR;
               end else begin
                  len_d      = in_data[ADDR_W:0];
                  wordCnt_d  = '0;
                  addr_d     = '0;
                  checksum_d = 8'd0;
                  asmClear   = 1'b1;
                  state_d    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               asmValid   = 1'b1;
               checksum_d = checksum_q ^ in_data;
               if (asmLast) begin
                  addr_d    = wordCnt_q[ADDR_W-1:0];
                  wordCnt_d = wordCnt_q + WordOne;
                  if ((wordCnt_q + WordOne) == len_q) begin
                     state_d = ST_CHK;
                  end
               end
            end
         end
         ST_CHK: begin
            if (xfer) begin
               state_d = (in_data == checksum_q) ? ST_DONE : ST_ERR;
            end
         end
         ST_DONE, ST_ERR: begin
            if (start) begin
               wordCnt_d = '0;
               state_d   = ST_LEN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         wordCnt_q  <= '0;
         addr_q     <= '0;
         checksum_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wordCnt_q  <= wordCnt_d;
         addr_q     <= addr_d;
         checksum_q <= checksum_d;
      end
   end

   byte_to_word u_byteToWord (
      .clk_i       (clk),
      .reset_i     (reset),
      .clear_i     (asmClear),
      .byteValid_i (asmValid),
      .byteData_i  (in_data),
      .lastByte_o  (asmLast),
      .wordValid_o (asmWordValid),
      .word_o      (asmWord)
   );

   // Status outputs are plain decodes of the registered state, so in_ready
   // never has a combinational path from in_valid.
   assign busy         = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
   assign in_ready     = busy;
   assign done         = (state_q == ST_DONE);
   assign error        = (state_q == ST_ERR);
   assign core_reset   = (state_q != ST_DONE);
   assign imem_we      = asmWordValid;
   assign imem_wdata   = asmWord;
   assign imem_addr    = addr_q;
   assign words_loaded = wordCnt_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Streams a program image into the RISC-V single-cycle core's instruction memory over a byte-wide valid/ready channel (UART or debug bridge side), then releases the core from reset. It is the in-hardware writer of `instr_mem` and replaces file-based preload for FPGA bring-up. The block sits beside `RISC_V_Single_Cycle`, drives its instruction-memory write port, and owns the core's reset.

## Interface
- `DEPTH`, 64: instruction-memory depth in 32-bit words.
- `ADDR_W`, 6: word-address width, equal to clog2(DEPTH).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `in_data`  in  8  image byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word to write.
- `core_reset`  out  1  holds the core in reset; active-high.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky: the last load succeeded.
- `error`  out  1  sticky: the last load failed.
- `words_loaded`  out  ADDR_W+1  count of words written in the current or last load.

## Operation
- Image format: byte 0 is N, the word count. Then 4·N data bytes, little-endian per word, words in order starting at address 0. Last comes one checksum byte, equal to the XOR of all 4·N data bytes.
- States: IDLE → LEN → DATA → CHK → DONE or ERR. DONE and ERR return to LEN on `start`.
- IDLE: reset state. `core_reset`=1, `in_ready`=0. On `start`, go to LEN.
- LEN: accept one byte.
  - N=0 or N>DEPTH: go to ERR.
  - Otherwise latch N, clear the word counter, address, byte index and checksum, and go to DATA.
- DATA: accept bytes and shift them into the word assembly register.
  - The byte index runs 0..3. Byte k goes to bits [8k+7:8k].
  - Every accepted byte is XORed into the running checksum.
  - After byte index 3, write the word and increment the address and `words_loaded`.
  - After word N, go to CHK.
- CHK: accept one byte. If it equals the checksum, go to DONE; otherwise go to ERR.
- DONE: `done`=1, `core_reset`=0, `in_ready`=0.
- ERR: `error`=1, `core_reset`=1, `in_ready`=0. Words already written stay in memory.
- On entry to LEN from DONE or ERR: clear `done`, `error` and `words_loaded`, and set `core_reset`=1.
- `busy`=1 in LEN, DATA and CHK.
- `start` in LEN, DATA or CHK is ignored. A load cannot be restarted mid-stream except by `reset`.
- Bytes presented in IDLE, DONE or ERR are not consumed, because `in_ready`=0.

## Timing
- A byte transfers on any rising edge where `in_valid`=1 and `in_ready`=1. `in_ready` is registered and depends only on state, never on `in_valid`.
- Sustained rate is one byte per cycle with no bubbles, including across word boundaries and the LEN→DATA and DATA→CHK transitions.
- Write latency: `imem_we` is a registered 1-cycle pulse, asserted the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` are valid in that same cycle.
- `words_loaded` updates in the same cycle as `imem_we`.
- Last write vs. checksum: the pulse for word N-1 overlaps the CHK state. If the checksum byte arrives the very next cycle, the write still completes, and DONE is entered no earlier than the cycle after the final `imem_we`.
- `core_reset` falls on the cycle DONE is entered, which is at least one cycle after the last write.
- Reset values, applying mid-load as well:
  - state=IDLE
  - `core_reset`=1
  - `in_ready`=0
  - `imem_we`=0
  - `imem_addr`=0
  - `imem_wdata`=0
  - `busy`=0
  - `done`=0
  - `error`=0
  - `words_loaded`=0
- Reset mid-load drops any partial word without writing it.
- Address never wraps: N≤DEPTH guarantees the maximum address is DEPTH-1.
- Arithmetic: `words_loaded` is ADDR_W+1 bits wide so it can hold DEPTH.

## Structure
- Shared package `riscv_pkg`:
  - state enum `loader_state_t`
  - `IMEM_DEPTH`
  - `IMEM_ADDR_W`
- One natural sub-module, `byte_to_word`. It holds the 4-byte assembler with index counter and emits a word-valid pulse. The FSM, counters and checksum stay in `imem_loader`.

## Test plan
- N=3, words 0x00500293, 0x00A00313, 0x00730393, correct checksum:
  - exactly three `imem_we` pulses, at addresses 0, 1, 2, with exact `imem_wdata` values
  - `done`=1, `words_loaded`=3, `core_reset` falls after the third write
- N=0, and separately N=65 with DEPTH=64: ERR directly from LEN, no `imem_we` pulses, `error`=1, `core_reset`=1.
- N=2 with the checksum byte off by 0x01: two writes occur, then `error`=1 and `core_reset` stays 1.
- Random `in_valid` gaps throughout a 4-word load: data and addresses are identical to the gap-free run, and every accepted byte coincides with `in_ready`=1.
- `reset` asserted after 6 data bytes:
  - all outputs return to reset values the next cycle
  - address 1 is never written
  - a following full load succeeds
- `start` pulsed mid-DATA is ignored. After DONE, a second `start` with N=1 clears `done`, raises `core_reset`, and rewrites address 0 only.
